// File: rtl/vga_frame_reader.sv
// VGA scan-out from frame-buffer RAM port B: timing counters, RAM address, RGB332 -> RGB444, 2^SCALE upscale.
// Optional: define VGA_READER_FRAME_START_EN for a one-clock frame_start pulse when pixel (0,0) is presented.
module vga_frame_reader #(
    parameter int          H_ACTIVE   = 640,
    parameter int          H_FP       = 16,
    parameter int          H_SYNC     = 96,
    parameter int          H_BP       = 48,
    parameter int          V_ACTIVE   = 480,
    parameter int          V_FP       = 10,
    parameter int          V_SYNC     = 2,
    parameter int          V_BP       = 33,
    parameter int          X_BITS     = 8,
    parameter int          Y_BITS     = 7,
    parameter int          SCALE      = 1,
    parameter logic [11:0] BORDER_RGB = 12'h000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pix_en,
    output logic [X_BITS+Y_BITS-1:0] addr_b,
    input  logic [7:0]               dout_b,
    output logic                     hsync,
    output logic                     vsync,
    output logic                     video_on,
    output logic [11:0]              rgb,
    output logic                     frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int XS      = X_BITS + SCALE;
    localparam int YS      = Y_BITS + SCALE;
    // Counters are kept wide enough for both the timing range and the image slice.
    localparam int HW      = ($clog2(H_TOTAL) > XS) ? $clog2(H_TOTAL) : XS + 1;
    localparam int VW      = ($clog2(V_TOTAL) > YS) ? $clog2(V_TOTAL) : YS + 1;
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          active, in_img, hs_win, vs_win;
    logic [11:0]   rgb_exp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    assign active  = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
    assign in_img  = ((h_cnt >> XS) == '0) && ((v_cnt >> YS) == '0);
    assign hs_win  = (int'(h_cnt) >= H_ACTIVE + H_FP) && (int'(h_cnt) < H_ACTIVE + H_FP + H_SYNC);
    assign vs_win  = (int'(v_cnt) >= V_ACTIVE + V_FP) && (int'(v_cnt) < V_ACTIVE + V_FP + V_SYNC);

    // Address runs through blanking too so the RAM read is always one clock ahead of the next tick.
    assign addr_b  = {v_cnt[YS-1:SCALE], h_cnt[XS-1:SCALE]};
    assign rgb_exp = {dout_b[7:5], dout_b[7], dout_b[4:2], dout_b[4], dout_b[1:0], dout_b[1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync    <= 1'b1;
            vsync    <= 1'b1;
            video_on <= 1'b0;
            rgb      <= 12'h000;
        end else if (pix_en) begin
            hsync    <= ~hs_win;
            vsync    <= ~vs_win;
            video_on <= active;
            rgb      <= !active ? 12'h000 : (in_img ? rgb_exp : BORDER_RGB);
        end
    end

`ifdef VGA_READER_FRAME_START_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) frame_start <= 1'b0;
        else       frame_start <= pix_en && (h_cnt == '0) && (v_cnt == '0);
    end
`else
    assign frame_start = 1'b0;
`endif

endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench for vga_frame_reader: full-size instance for line/address/colour, tiny-timing instance for frame wrap.
module tb_vga_frame_reader;
    logic        clk = 1'b0, reset = 1'b1, pix_en = 1'b0;
    logic [14:0] addr_b;
    logic [7:0]  dout_b;
    logic        hsync, vsync, video_on, frame_start;
    logic [11:0] rgb;
    logic [2:0]  addr_s;
    logic [7:0]  dout_s;
    logic        hs_s, vs_s, vid_s, fs_s;
    logic [11:0] rgb_s;

    logic [7:0]  ram   [0:32767];
    logic [7:0]  ram_s [0:7];

`ifdef VGA_READER_FRAME_START_EN
    localparam int FS_ON = 1;
`else
    localparam int FS_ON = 0;
`endif

    vga_frame_reader #(.BORDER_RGB(12'h123)) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .addr_b(addr_b), .dout_b(dout_b),
        .hsync(hsync), .vsync(vsync), .video_on(video_on), .rgb(rgb), .frame_start(frame_start));

    vga_frame_reader #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .X_BITS(2), .Y_BITS(1), .SCALE(1)
    ) dut_s (
        .clk(clk), .reset(reset), .pix_en(pix_en), .addr_b(addr_s), .dout_b(dout_s),
        .hsync(hs_s), .vsync(vs_s), .video_on(vid_s), .rgb(rgb_s), .frame_start(fs_s));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        dout_b <= ram[addr_b];
        dout_s <= ram_s[addr_s];
    end

    int fs_main_n = 0, fs_small_n = 0;
    always @(posedge clk) begin
        if (frame_start) fs_main_n <= fs_main_n + 1;
        if (fs_s)        fs_small_n <= fs_small_n + 1;
    end

    typedef struct {
        int          h;
        int          v;
        logic [14:0] addr;
        logic        vid;
        logic        hs;
        logic [11:0] rgb;
    } vec_t;
    vec_t tab[15];

    int errors = 0, checks = 0;
    int period = 2;
    int th = 0, tv = 0, sh = 0, sv = 0;
    logic        o_hs, o_vs, o_vid, o_hs_s, o_vs_s, o_vid_s, o_fs_s;
    logic [11:0] o_rgb, o_rgb_s;
    logic [13:0] seq [1200];
    int rec_n = 0;
    int vid_cnt = 0, hs_start = -1, hs_len = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors < 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One pixel tick: pix_en high for one clock, outputs captured just after the tick edge.
    task automatic tick();
        pix_en = 1'b1;
        @(negedge clk);
        pix_en = 1'b0;
        o_hs = hsync; o_vs = vsync; o_vid = video_on; o_rgb = rgb;
        o_hs_s = hs_s; o_vs_s = vs_s; o_vid_s = vid_s; o_rgb_s = rgb_s; o_fs_s = fs_s;
        th++;
        if (th == 800) begin th = 0; tv = (tv == 524) ? 0 : tv + 1; end
        sh++;
        if (sh == 15) begin sh = 0; sv = (sv == 7) ? 0 : sv + 1; end
        repeat (period - 1) @(negedge clk);
    endtask

    task automatic adv();
        int ph, pv;
        ph = th; pv = tv;
        tick();
        if (rec_n < 1200) begin seq[rec_n] = {o_hs, o_vid, o_rgb}; rec_n++; end
        if (pv == 1) begin
            if (o_vid) vid_cnt++;
            if (!o_hs) begin
                if (hs_len == 0) hs_start = ph;
                hs_len++;
            end
        end
    endtask

    task automatic restart();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        th = 0; tv = 0; sh = 0; sv = 0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int fs0, ph, pv, mism, amis, first_bad;
        logic [14:0] ea;
        logic [15:0] es;
        for (int a = 0; a < 32768; a++) ram[a] = 8'(a) ^ 8'hA5;
        ram[517] = 8'hE3;
        for (int a = 0; a < 8; a++) ram_s[a] = 8'hE3;

        tab[0]  = '{0,   0, 15'd0,   1'b1, 1'b1, 12'hB25};
        tab[1]  = '{511, 0, 15'd255, 1'b1, 1'b1, 12'h4DA};
        tab[2]  = '{512, 0, 15'd0,   1'b1, 1'b1, 12'h123};
        tab[3]  = '{639, 0, 15'd63,  1'b1, 1'b1, 12'h123};
        tab[4]  = '{640, 0, 15'd64,  1'b0, 1'b1, 12'h000};
        tab[5]  = '{655, 0, 15'd71,  1'b0, 1'b1, 12'h000};
        tab[6]  = '{656, 0, 15'd72,  1'b0, 1'b0, 12'h000};
        tab[7]  = '{751, 0, 15'd119, 1'b0, 1'b0, 12'h000};
        tab[8]  = '{752, 0, 15'd120, 1'b0, 1'b1, 12'h000};
        tab[9]  = '{799, 0, 15'd143, 1'b0, 1'b1, 12'h000};
        tab[10] = '{0,   1, 15'd0,   1'b1, 1'b1, 12'hB25};
        tab[11] = '{3,   2, 15'd257, 1'b1, 1'b1, 12'hB20};
        tab[12] = '{10,  5, 15'd517, 1'b1, 1'b1, 12'hF0F};
        tab[13] = '{600, 5, 15'd556, 1'b1, 1'b1, 12'h123};
        tab[14] = '{700, 5, 15'd606, 1'b0, 1'b0, 12'h000};

        // Reset asserted mid-line while ticking.
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        th = 0; tv = 0; sh = 0; sv = 0;
        repeat (300) tick();
        chk("pre_reset_vid", {31'd0, video_on}, 32'd1);
        #3 reset = 1'b1;
        #1;
        chk("rst_outputs", {hsync, vsync, video_on, rgb}, {1'b1, 1'b1, 1'b0, 12'h000});
        chk("rst_addr", {17'd0, addr_b}, 32'd0);
        repeat (4) begin @(negedge clk); pix_en = ~pix_en; end
        pix_en = 1'b0;
        chk("rst_hold", {hsync, vsync, video_on, rgb, addr_b}, {1'b1, 1'b1, 1'b0, 12'h000, 15'd0});
        @(negedge clk);
        reset = 1'b0;
        th = 0; tv = 0; sh = 0; sv = 0;
        repeat (2) @(negedge clk);

        // Table-driven positions, pix_en every 2 clocks.
        fs0 = fs_main_n;
        for (int i = 0; i < 15; i++) begin
            while (!(th == tab[i].h && tv == tab[i].v)) adv();
            chk($sformatf("addr(%0d,%0d)", th, tv), {17'd0, addr_b}, {17'd0, tab[i].addr});
            adv();
            chk($sformatf("out(%0d,%0d)", tab[i].h, tab[i].v), {o_vid, o_hs, o_vs, o_rgb},
                {tab[i].vid, tab[i].hs, 1'b1, tab[i].rgb});
        end
        chk("line1_video_ticks", vid_cnt, 640);
        chk("line1_hsync_start", hs_start, 656);
        chk("line1_hsync_len", hs_len, 96);
        chk("fs_main_count", fs_main_n - fs0, FS_ON);

        // Small-timing instance: two full frames, including the double wrap.
        while (!(sh == 0 && sv == 0)) tick();
        fs0 = fs_small_n;
        for (int k = 0; k < 240; k++) begin
            ph = sh; pv = sv;
            tick();
            es[15]   = !(ph >= 10 && ph < 13);
            es[14]   = !(pv >= 5 && pv < 7);
            es[13]   = (ph < 8) && (pv < 4);
            es[12]   = (FS_ON == 1) && ph == 0 && pv == 0;
            es[11:0] = es[13] ? 12'hF0F : 12'h000;
            chk($sformatf("small(%0d,%0d)", ph, pv), {16'd0, o_hs_s, o_vs_s, o_vid_s, o_fs_s, o_rgb_s},
                {16'd0, es});
            if (ph == 14 && pv == 7) chk("small_wrap_addr", {29'd0, addr_s}, 32'd0);
        end
        chk("fs_small_count", fs_small_n - fs0, 2 * FS_ON);

        // Sparse ticks: same pixel stream as the 2-clock run, address steps by one position per tick.
        restart();
        period = 4;
        mism = 0; amis = 0; first_bad = -1;
        for (int k = 0; k < 1200; k++) begin
            tick();
            if ({o_hs, o_vid, o_rgb} !== seq[k]) begin
                mism++;
                if (first_bad < 0) first_bad = k;
            end
            ea = {tv[6:0], 8'(th >> 1)};
            ea[14:8] = 7'(tv >> 1);
            if (addr_b !== ea) amis++;
        end
        if (mism != 0) $display("FAIL sparse_seq: first differing tick %0d", first_bad);
        chk("sparse_seq_mismatches", mism, 0);
        chk("sparse_addr_mismatches", amis, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vga_frame_reader.md
# vga_frame_reader

- Display-side reader for the VGA frame buffer: owns port B (addr_b/dout_b) of the dual-port pixel RAM and scans it out as a 640x480 VGA stream.
- Generates horizontal and vertical timing counters, the RAM read address for each pixel, and sync/blank signals.
- Expands RGB332 words to 12-bit RGB, with each image pixel upscaled 2^SCALE times in both axes.
- Sits between the frame-buffer RAM and the board VGA pins; the bus-side writer uses RAM port A independently.

## Interface
Parameters:
- H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48: horizontal timing in pixel ticks
- V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33: vertical timing in lines
- X_BITS 8: image width = 2^X_BITS RAM pixels
- Y_BITS 7: image height = 2^Y_BITS RAM pixels
- SCALE 1: each RAM pixel covers 2^SCALE x 2^SCALE screen pixels
- BORDER_RGB 12'h000: colour driven for active pixels outside the image region

Ports:
- clk, input, 1: system clock
- reset, input, 1: asynchronous, active-high reset
- pix_en, input, 1: pixel tick; at most one clock in every two
- addr_b, output, X_BITS+Y_BITS: RAM port B address
- dout_b, input, 8: RAM port B data, RGB332 {r[2:0],g[2:0],b[1:0]}
- hsync, output, 1: active-low horizontal sync
- vsync, output, 1: active-low vertical sync
- video_on, output, 1: high during active area
- rgb, output, 12: {r4,g4,b4}
- frame_start, output, 1: frame marker (see Configuration)

## Operation
- h_cnt counts 0..H_TOTAL-1 on each pix_en, then wraps to 0. H_TOTAL = sum of the H parameters.
- v_cnt increments on each h_cnt wrap and counts 0..V_TOTAL-1, then wraps to 0.
- Both counters are clear on reset.
- Active area: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- Sync windows:
  - hsync low for H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync low over the same construction on v_cnt.
- Image region: h_cnt < 2^(X_BITS+SCALE) and v_cnt < 2^(Y_BITS+SCALE).
- addr_b = {v_cnt[Y_BITS+SCALE-1:SCALE], h_cnt[X_BITS+SCALE-1:SCALE]}.
  - Combinational from the counters, truncated to ADDR width.
  - Never gated: the address is driven during blanking too.
- Colour expansion: r4={r,r[2]}, g4={g,g[2]}, b4={b,b}.
- Output stage, registered on pix_en, captures for the current counter position:
  - hsync, vsync, video_on
  - rgb = expanded dout_b inside the image region, BORDER_RGB in active area outside it, 12'h000 when not active.
- Reset values: hsync=1, vsync=1, video_on=0, rgb=0, frame_start=0.
  - addr_b resets to 0 because it follows the cleared counters.

## Timing
- The RAM registers addr_b on every clk, and dout_b is valid one clock later.
- pix_en spacing of ≥2 clocks guarantees dout_b equals the data for the current counter position at the next pix_en edge.
- Latency: every output reflects the counter position one pixel tick earlier; sync, blank and colour stay mutually aligned.
- Outputs hold between ticks.
- Counter wrap: at h_cnt=H_TOTAL-1 with v_cnt=V_TOTAL-1, a tick sets both counters to 0 in the same edge.
- Reset mid-frame: counters and outputs clear immediately (asynchronously). The next frame starts at (0,0) on the first tick after release.
- First tick after reset release, if it lands in the first clock: rgb for pixel (0,0) of that frame is undefined. Sync and blank are still correct.

## Configuration
- VGA_READER_FRAME_START_EN
  - Defined: frame_start is registered on pix_en and is high for exactly one clock, the edge on which the output stage presents pixel (0,0).
  - Undefined: frame_start is tied 0 and no logic is generated.

## Test plan
- Reset: assert reset mid-line with pix_en toggling.
  - Required: hsync=1, vsync=1, video_on=0, rgb=0, addr_b=0 immediately.
  - Required: first post-release tick outputs the status of (0,0).
- Line timing, pix_en every 2 clocks:
  - video_on high for 640 ticks, then hsync low starting 656 ticks after the first active pixel, for 96 ticks.
  - Line period 800 ticks; frame period 525 lines; vsync low on output lines 490-491.
- Address map, defaults: at h_cnt=10, v_cnt=5, addr_b=517 ({2,5}).
  - Preload RAM[517]=8'hE3 -> rgb=12'hF0F one tick later.
- Border: h_cnt=600, v_cnt=100 with BORDER_RGB=12'h123 -> rgb=12'h123, video_on=1.
  - During horizontal blank: rgb=0.
- Sparse ticks: pix_en every 4 clocks with a RAM ramp pattern.
  - Required: the output pixel sequence is identical to the 2-clock case, with no skipped or duplicated addresses.
- VGA_READER_FRAME_START_EN defined: exactly one 1-clock frame_start pulse per 420000 ticks, coincident with (0,0) output.
  - Undefined: frame_start stays 0.
